m_gt_qpll_ctrl: RTL and testbench

//  Parametrised power-up/reset/lock supervisor for NUM_QPLL GTHE4 common QPLLs; drives each QPLL's PD and RESET pins.

---
 rtl/m_gt_qpll_ctrl.sv | 148 ++++++++++++++
 tb/tb_m_gt_qpll_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_gt_qpll_ctrl.sv
// Per-QPLL power-up/reset/lock supervisor: drives PD/RESET, debounces lock, retries on timeout or lock loss.
// Outputs are registered one cycle behind the FSM; lock is qualified 2 (sync) + LOCK_STABLE cycles after lock rises, no backpressure.
module m_gt_qpll_ctrl #(
  parameter int NUM_QPLL     = 2,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  sysclk_i,
  input  logic                  resetn_i,
  input  logic [NUM_QPLL-1:0]   enable_i,
  input  logic [NUM_QPLL-1:0]   restart_i,
  input  logic [NUM_QPLL-1:0]   qpll_lock_i,
  output logic [NUM_QPLL-1:0]   qpll_pd_o,
  output logic [NUM_QPLL-1:0]   qpll_reset_o,
  output logic [NUM_QPLL-1:0]   locked_o,
  output logic [NUM_QPLL-1:0]   fail_o,
  output logic [4*NUM_QPLL-1:0] retry_cnt_o,
  output logic                  all_locked_o
);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB_END   = SW'(LOCK_STABLE);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  logic all_locked_q;

  for (genvar g = 0; g < NUM_QPLL; g++) begin : g_ch
    logic          lk_m_q, lk_s_q;
    logic [2:0]    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d, tcnt_nx;
    logic [SW-1:0] scnt_q, scnt_d, scnt_nx;
    logic [3:0]    retry_q, retry_d, retry_o_q;
    logic          pd_q, rst_q, locked_q, fail_q;

    assign tcnt_nx = tcnt_q + TW'(1);
    assign scnt_nx = lk_s_q ? scnt_q + SW'(1) : '0;

    always_comb begin
      state_d = state_q;
      rcnt_d  = '0;
      tcnt_d  = '0;
      scnt_d  = '0;
      retry_d = retry_q;
      if (!enable_i[g]) begin
        state_d = S_OFF;
        retry_d = '0;
      end else if (restart_i[g] && (state_q != S_OFF)) begin
        state_d = S_RESET;
        retry_d = '0;
      end else begin
        case (state_q)
          S_OFF: state_d = S_RESET;
          S_RESET: begin
            if (rcnt_q == RST_LAST) state_d = S_WAIT;
            else                    rcnt_d  = rcnt_q + RW'(1);
          end
          S_WAIT: begin
            // A lock qualifying on the timeout cycle takes precedence.
            if (scnt_nx == STB_END) begin
              state_d = S_LOCKED;
            end else if (tcnt_nx == TMO_END) begin
              if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = S_RESET;
              end else begin
                state_d = S_FAIL;
              end
            end else begin
              tcnt_d = tcnt_nx;
              scnt_d = scnt_nx;
            end
          end
          S_LOCKED: begin
            if (!lk_s_q) begin
              if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = S_RESET;
              end else begin
                state_d = S_FAIL;
              end
            end
          end
          S_FAIL:  state_d = S_FAIL;
          default: state_d = S_OFF;
        endcase
      end
    end

    always_ff @(posedge sysclk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        lk_m_q    <= 1'b0;
        lk_s_q    <= 1'b0;
        state_q   <= S_OFF;
        rcnt_q    <= '0;
        tcnt_q    <= '0;
        scnt_q    <= '0;
        retry_q   <= '0;
        retry_o_q <= '0;
        pd_q      <= 1'b1;
        rst_q     <= 1'b1;
        locked_q  <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        lk_m_q    <= qpll_lock_i[g];
        lk_s_q    <= lk_m_q;
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
        tcnt_q    <= tcnt_d;
        scnt_q    <= scnt_d;
        retry_q   <= retry_d;
        retry_o_q <= retry_q;
        pd_q      <= (state_q == S_OFF) || (state_q == S_FAIL);
        rst_q     <= (state_q == S_OFF) || (state_q == S_RESET) || (state_q == S_FAIL);
        locked_q  <= (state_q == S_LOCKED);
        fail_q    <= (state_q == S_FAIL);
      end
    end

    assign qpll_pd_o[g]          = pd_q;
    assign qpll_reset_o[g]       = rst_q;
    assign locked_o[g]           = locked_q;
    assign fail_o[g]             = fail_q;
    assign retry_cnt_o[4*g +: 4] = retry_o_q;
  end

  // Disabled channels are ignored, but at least one must be enabled.
  always_ff @(posedge sysclk_i or negedge resetn_i) begin
    if (!resetn_i) all_locked_q <= 1'b0;
    else           all_locked_q <= (|enable_i) & (&(locked_o | ~enable_i));
  end

  assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_m_gt_qpll_ctrl.sv
// Bench for m_gt_qpll_ctrl: directed scenarios then random traffic, all cycles compared with a reference model.
module tb_m_gt_qpll_ctrl;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 50;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] enable, restart, lock;
  logic [1:0] pd, rst, lkd, fl;
  logic [7:0] rty;
  logic       alll;
  logic [16:0] obs;

  localparam logic [16:0] RST_VAL = {2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 1'b0};

  m_gt_qpll_ctrl #(
    .NUM_QPLL(2), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sysclk_i(clk), .resetn_i(resetn), .enable_i(enable), .restart_i(restart),
    .qpll_lock_i(lock), .qpll_pd_o(pd), .qpll_reset_o(rst), .locked_o(lkd),
    .fail_o(fl), .retry_cnt_o(rty), .all_locked_o(alll)
  );

  always #5 clk = ~clk;
  assign obs = {pd, rst, lkd, fl, rty, alll};

  int nchk = 0, npass = 0, nfail = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    nchk++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, o, e);
    end
  endtask

  // Reference model: mode plus cycles-in-mode and consecutive-lock run length.
  typedef enum int {M_OFF, M_PULSE, M_WAIT, M_UP, M_DEAD} mode_t;
  mode_t md [2];
  int    age [2], run [2], rtc [2];
  bit    sy1 [2], sy2 [2];
  logic [1:0] e_pd, e_rst, e_lk, e_fail;
  logic [7:0] e_rty;
  logic       e_all;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      md[c] = M_OFF; age[c] = 0; run[c] = 0; rtc[c] = 0; sy1[c] = 0; sy2[c] = 0;
    end
    e_pd = 2'b11; e_rst = 2'b11; e_lk = 2'b00; e_fail = 2'b00; e_rty = 8'h00; e_all = 1'b0;
  endtask

  task automatic attempt_failed(int c);
    if (rtc[c] < MAX_RETRY) begin
      rtc[c]++; md[c] = M_PULSE; age[c] = 0;
    end else begin
      md[c] = M_DEAD;
    end
  endtask

  task automatic model_step();
    bit lk;
    if (!resetn) begin
      model_reset();
      return;
    end
    e_all = (|enable) & (&(e_lk | ~enable));
    for (int c = 0; c < 2; c++) begin
      e_pd[c]   = (md[c] == M_OFF) || (md[c] == M_DEAD);
      e_rst[c]  = (md[c] != M_WAIT) && (md[c] != M_UP);
      e_lk[c]   = (md[c] == M_UP);
      e_fail[c] = (md[c] == M_DEAD);
      e_rty[4*c +: 4] = 4'(rtc[c]);
      lk = sy2[c]; sy2[c] = sy1[c]; sy1[c] = lock[c];
      if (!enable[c]) begin
        md[c] = M_OFF; rtc[c] = 0;
      end else if (restart[c] && md[c] != M_OFF) begin
        md[c] = M_PULSE; age[c] = 0; rtc[c] = 0;
      end else begin
        case (md[c])
          M_OFF: begin md[c] = M_PULSE; age[c] = 0; end
          M_PULSE: begin
            age[c]++;
            if (age[c] == RST_CYCLES) begin md[c] = M_WAIT; age[c] = 0; run[c] = 0; end
          end
          M_WAIT: begin
            age[c]++;
            run[c] = lk ? run[c] + 1 : 0;
            if (run[c] == LOCK_STABLE)        md[c] = M_UP;
            else if (age[c] == LOCK_TIMEOUT)  attempt_failed(c);
          end
          M_UP: if (!lk) attempt_failed(c);
          default: ;
        endcase
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", obs, {e_pd, e_rst, e_lk, e_fail, e_rty, e_all});
  endtask

  initial begin
    int n, w, pulses, waitc, rate [2], sel;
    bit prev, cur;
    resetn = 0; enable = 0; restart = 0; lock = 0;
    model_reset();

    // Reset held while other inputs toggle
    for (int i = 0; i < 6; i++) begin
      enable = 2'($urandom); restart = 2'($urandom); lock = 2'($urandom);
      cyc();
      chk("reset_hold", obs, RST_VAL);
    end
    enable = 0; restart = 0; lock = 0;
    cyc();
    resetn = 1;
    cyc();

    // Bring up channel 0
    enable = 2'b01;
    for (int i = 0; i < 10; i++) begin cyc(); if (!pd[0]) break; end
    n = 1;
    for (int i = 0; i < 20; i++) begin cyc(); if (!rst[0]) break; n++; end
    chk("rst_width", n, RST_CYCLES);
    repeat (10) cyc();
    lock = 2'b01;
    n = 0;
    for (int i = 0; i < 40; i++) begin cyc(); n++; if (lkd[0]) break; end
    chk("lock_latency", n, 2 + LOCK_STABLE + 1);
    chk("all_lag_a", alll, 0);
    cyc();
    chk("all_lag_b", alll, 1);

    // Never-locking channel exhausts its retries
    resetn = 0; lock = 0; enable = 2'b01;
    cyc();
    resetn = 1;
    pulses = 0; waitc = 0; prev = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      cur = rst[0] & ~pd[0];
      if (cur && !prev) pulses++;
      prev = cur;
      if (!pd[0] && !rst[0]) waitc++;
      if (fl[0]) break;
    end
    chk("fail_pulses", pulses, MAX_RETRY + 1);
    chk("fail_wait_cycles", waitc, (MAX_RETRY + 1) * LOCK_TIMEOUT);
    chk("fail_flag", fl[0], 1);
    chk("fail_retry", rty[3:0], MAX_RETRY);
    chk("fail_pd", pd[0], 1);
    restart = 2'b01;
    cyc();
    restart = 0;
    cyc();
    chk("restart_pd_rst", {pd[0], rst[0]}, 2'b01);
    chk("restart_retry", rty[3:0], 0);
    chk("restart_fail", fl[0], 0);

    // Glitch during debounce restarts the stable count
    resetn = 0; enable = 2'b11; lock = 2'b10;
    cyc();
    resetn = 1;
    for (int i = 0; i < 30; i++) begin cyc(); if (!pd[0] && !rst[0]) break; end
    lock[0] = 1;
    repeat (6) cyc();
    lock[0] = 0;
    cyc();
    lock[0] = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin cyc(); n++; if (lkd[0]) break; end
    chk("relock_latency", n, 2 + LOCK_STABLE + 1);

    // Lost lock on channel 0 while channel 1 stays locked
    cyc();
    cyc();
    chk("all_both", alll, 1);
    lock[0] = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin cyc(); n++; lock[0] = 1; if (!lkd[0]) break; end
    chk("loss_latency", n, 4);
    chk("loss_retry", rty[3:0], 1);
    chk("loss_rst", rst[0], 1);
    w = 1;
    for (int i = 0; i < 20; i++) begin cyc(); if (!rst[0]) break; w++; end
    chk("loss_pulse", w, RST_CYCLES);
    chk("ch1_kept", {lkd[1], rty[7:4]}, 5'b1_0000);

    // Disable beats restart
    enable = 2'b10; restart = 2'b01;
    cyc();
    restart = 0;
    cyc();
    chk("en_over_restart", {pd[0], rst[0], lkd[0]}, 3'b110);

    // Asynchronous reset in the middle of WAIT_LOCK
    lock[0] = 0; enable = 2'b11;
    for (int i = 0; i < 30; i++) begin cyc(); if (!pd[0] && !rst[0]) break; end
    repeat (5) cyc();
    #2;
    resetn = 0;
    #1;
    model_reset();
    chk("async_reset", obs, RST_VAL);
    cyc();
    resetn = 1;

    // Random traffic
    rate[0] = 30; rate[1] = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) begin
        for (int c = 0; c < 2; c++) begin
          case ($urandom_range(0, 2))
            0:       rate[c] = 3;
            1:       rate[c] = 30;
            default: rate[c] = 300;
          endcase
        end
      end
      for (int c = 0; c < 2; c++)
        if ($urandom_range(1, rate[c]) == 1) lock[c] = ~lock[c];
      if ($urandom_range(0, 299) == 0) begin
        sel = int'($urandom_range(0, 1));
        enable[sel] = ~enable[sel];
      end
      restart = 0;
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 149) == 0) restart[c] = 1;
      resetn = ($urandom_range(0, 799) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
